// File: rtl/ucsbece154_imem_pkg.sv
// Shared definitions for the text-memory boot loader and the text memory itself.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ucsbece154_imem_pkg;

    // Byte address of text word 0; the text memory decodes against the same value.
    localparam logic [31:0] TEXT_START_DEFAULT = 32'h0001_0000;

    // Width of the length prefix carried at the head of the boot stream.
    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/ucsbece154_imem_loader_if.sv
// Boot byte stream plus text-memory write port, bundled between loader and environment.
// Latency: n/a (wires only).
// Backpressure: rx_* is valid/ready; a byte moves when rx_valid_i && rx_ready_o at the edge.
// master: loader side (consumes rx stream, drives write port).
// slave : environment side (drives rx stream, observes write port).
interface ucsbece154_imem_loader_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        we_o;
    logic [31:0] wa_o;
    logic [31:0] wd_o;

    modport master (
        input  rx_data_i, rx_valid_i,
        output rx_ready_o, we_o, wa_o, wd_o
    );

    modport slave (
        output rx_data_i, rx_valid_i,
        input  rx_ready_o, we_o, wa_o, wd_o
    );
endinterface

// File: rtl/ucsbece154_word_assembler.sv
// Packs accepted stream bytes little-endian into 32-bit words.
// Latency: word_dat/word_full are combinational with the 4th byte's load strobe.
// Backpressure: none of its own; it only advances on load, so gaps keep the partial word.
// Ports: clk, reset (sync, active-high), clear (restart at lane 0), load (byte accepted),
//        byte_dat (incoming byte), word_dat (assembled word), word_full (4th byte this cycle).
module ucsbece154_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word_dat,
    output logic        word_full
);

    logic [23:0] lanes;
    logic [1:0]  byte_idx;

    // Lane 3 is never stored: the word completes on the cycle its top byte
    // arrives, so the top byte is taken straight from the input.
    assign word_full = load && (byte_idx == 2'd3);
    assign word_dat  = {byte_dat, lanes};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lanes    <= '0;
            byte_idx <= '0;
        end else if (load) begin
            case (byte_idx)
                2'd0:    lanes[7:0]   <= byte_dat;
                2'd1:    lanes[15:8]  <= byte_dat;
                2'd2:    lanes[23:16] <= byte_dat;
                default: lanes        <= lanes;
            endcase
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/ucsbece154_imem_loader.sv
// Boot-time loader: length-prefixed byte stream -> one text-memory write per 32-bit word.
// Latency: write issued 1 cycle after a word's 4th byte; peak 1 word per 5 cycles.
// Backpressure: rx_ready_o is decoded from state only; stalls on rx_valid_i gaps without loss.
// Ports: clk, reset (sync, active-high), start_i (arm in IDLE/DONE/ERR), bus (stream + write port),
//        busy_o/cpu_reset_o (load in progress), done_o/err_o (sticky), words_o (words written).
module ucsbece154_imem_loader
    import ucsbece154_imem_pkg::*;
#(
    parameter int          TEXT_SIZE  = 64,
    parameter logic [31:0] TEXT_START = TEXT_START_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_i,
    ucsbece154_imem_loader_if.master   bus,
    output logic                       busy_o,
    output logic                       cpu_reset_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [15:0]                words_o
);

    localparam int IDX_W = $clog2(TEXT_SIZE + 1);

    loader_state_t     state;
    logic [7:0]        len_lo;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_full;
    logic [LEN_W-1:0]  word_cnt_nxt;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       asm_word;
    logic              word_full;
    logic              xfer;
    logic              start_ok;

    // Everything visible outside is either a register or a pure state decode,
    // so rx_ready_o never depends on rx_valid_i.
    assign bus.rx_ready_o = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
    assign bus.we_o       = (state == ST_WRITE);
    assign busy_o         = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                            (state == ST_DATA)   || (state == ST_WRITE);
    assign cpu_reset_o    = busy_o;
    assign done_o         = (state == ST_DONE);
    assign err_o          = (state == ST_ERR);

    assign xfer         = bus.rx_valid_i && bus.rx_ready_o;
    assign start_ok     = start_i && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign len_full     = {bus.rx_data_i, len_lo};
    assign word_cnt_nxt = LEN_W'(word_idx) + LEN_W'(1);

    ucsbece154_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .load      (xfer && (state == ST_DATA)),
        .byte_dat  (bus.rx_data_i),
        .word_dat  (asm_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            len_lo     <= '0;
            len        <= '0;
            word_idx   <= '0;
            words_o    <= '0;
            bus.wa_o   <= '0;
            bus.wd_o   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        state    <= ST_LEN_LO;
                        word_idx <= '0;
                        words_o  <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        len_lo <= bus.rx_data_i;
                        state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        len <= len_full;
                        // Zero length takes priority over the range check.
                        if (len_full == '0)
                            state <= ST_DONE;
                        else if (len_full > LEN_W'(TEXT_SIZE))
                            state <= ST_ERR;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (word_full) begin
                        state    <= ST_WRITE;
                        bus.wa_o <= TEXT_START + (32'(word_idx) << 2);
                        bus.wd_o <= asm_word;
                    end
                end
                ST_WRITE: begin
                    word_idx <= word_idx + IDX_W'(1);
                    words_o  <= words_o + 16'd1;
                    state    <= (word_cnt_nxt == len) ? ST_DONE : ST_DATA;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154_imem_loader.sv
// Directed bench for the boot loader: reset, two-word load, zero length, overflow,
// random-gap 64-word load, reset mid-load, and re-arm behaviour.
// Writes seen on the bus are logged and mirrored into a small text-memory model.
module tb_ucsbece154_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        busy_o;
    logic        cpu_reset_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] words_o;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int base;

    logic [31:0] log_addr [0:255];
    logic [31:0] log_data [0:255];
    logic [31:0] mem      [0:63];

    ucsbece154_imem_loader_if bus ();

    ucsbece154_imem_loader #(
        .TEXT_SIZE  (64),
        .TEXT_START (32'h0001_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .cpu_reset_o (cpu_reset_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .words_o     (words_o)
    );

    always #5 clk = ~clk;

    // Text-memory model: capture each write strobe once, mid-cycle.
    always @(negedge clk) begin
        if (bus.we_o === 1'b1) begin
            log_addr[wr_cnt[7:0]] <= bus.wa_o;
            log_data[wr_cnt[7:0]] <= bus.wd_o;
            mem[6'((bus.wa_o - 32'h0001_0000) >> 2)] <= bus.wd_o;
            wr_cnt <= wr_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present one byte after 'gap' idle cycles; returns on the negedge after it transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.rx_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        n = 0;
        while (bus.rx_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("rdy_wait", bus.rx_ready_o, 1'b1);
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        send_byte(w[7:0],   $urandom_range(0, maxgap));
        send_byte(w[15:8],  $urandom_range(0, maxgap));
        send_byte(w[23:16], $urandom_range(0, maxgap));
        send_byte(w[31:24], $urandom_range(0, maxgap));
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b ^ 8'hC3, b + 8'd17, ~b, b};
    endfunction

    initial begin
        reset          = 1'b1;
        start_i        = 1'b0;
        bus.rx_data_i  = 8'h00;
        bus.rx_valid_i = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk1 ("rst_ready", bus.rx_ready_o, 1'b0);
        chk1 ("rst_we",    bus.we_o,       1'b0);
        chk1 ("rst_busy",  busy_o,         1'b0);
        chk1 ("rst_cpu",   cpu_reset_o,    1'b0);
        chk1 ("rst_done",  done_o,         1'b0);
        chk1 ("rst_err",   err_o,          1'b0);
        chk32("rst_wa",    bus.wa_o,       32'h0);
        chk32("rst_wd",    bus.wd_o,       32'h0);
        chk32("rst_words", 32'(words_o),   32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk1 ("idle_ready", bus.rx_ready_o, 1'b0);

        // ---- two-word load, with a start pulse ignored while busy ----
        pulse_start();
        chk1("arm_busy",  busy_o,         1'b1);
        chk1("arm_cpu",   cpu_reset_o,    1'b1);
        chk1("arm_ready", bus.rx_ready_o, 1'b1);
        base = wr_cnt;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        start_i = 1'b1;
        send_byte(8'h78, 0);
        start_i = 1'b0;
        chk1("busy_start_ign", busy_o, 1'b1);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        chk1 ("w0_we", bus.we_o, 1'b1);
        chk32("w0_wa", bus.wa_o, 32'h0001_0000);
        chk32("w0_wd", bus.wd_o, 32'h1234_5678);
        chk1 ("w0_ready", bus.rx_ready_o, 1'b0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        chk1 ("w1_we",  bus.we_o, 1'b1);
        chk32("w1_wa",  bus.wa_o, 32'h0001_0004);
        chk32("w1_wd",  bus.wd_o, 32'hDEAD_BEEF);
        chk1 ("w1_cpu", cpu_reset_o, 1'b1);
        @(negedge clk);
        chk1 ("two_done",  done_o,        1'b1);
        chk1 ("two_cpu",   cpu_reset_o,   1'b0);
        chk1 ("two_we",    bus.we_o,      1'b0);
        chk32("two_words", 32'(words_o),  32'd2);
        chk32("two_wa_hold", bus.wa_o,    32'h0001_0004);
        chk32("two_wd_hold", bus.wd_o,    32'hDEAD_BEEF);
        chk32("two_wcnt",  32'(wr_cnt - base), 32'd2);
        chk32("two_log0",  log_data[base[7:0]], 32'h1234_5678);

        // ---- re-arm from DONE, then zero length ----
        pulse_start();
        chk1 ("rearm_done",  done_o,       1'b0);
        chk32("rearm_words", 32'(words_o), 32'd0);
        chk1 ("rearm_busy",  busy_o,       1'b1);
        base = wr_cnt;
        send_byte(8'h00, 0);
        chk1("zl_lenhi_done", done_o, 1'b0);
        send_byte(8'h00, 0);
        chk1 ("zl_done",  done_o,       1'b1);
        chk1 ("zl_busy",  busy_o,       1'b0);
        chk1 ("zl_cpu",   cpu_reset_o,  1'b0);
        chk32("zl_words", 32'(words_o), 32'd0);
        @(negedge clk);
        chk32("zl_wcnt", 32'(wr_cnt - base), 32'd0);

        // ---- overflow: LEN = 65 ----
        pulse_start();
        base = wr_cnt;
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        chk1("ov_err",   err_o,          1'b1);
        chk1("ov_ready", bus.rx_ready_o, 1'b0);
        chk1("ov_busy",  busy_o,         1'b0);
        chk1("ov_done",  done_o,         1'b0);
        bus.rx_data_i  = 8'hAA;
        bus.rx_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx_valid_i = 1'b0;
        chk1 ("ov_ready_hold", bus.rx_ready_o, 1'b0);
        chk1 ("ov_err_hold",   err_o,          1'b1);
        chk32("ov_wcnt", 32'(wr_cnt - base), 32'd0);
        pulse_start();
        chk1 ("ov_rearm_err",   err_o,        1'b0);
        chk32("ov_rearm_words", 32'(words_o), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h4433_2211, 0);
        chk1 ("ov1_we", bus.we_o, 1'b1);
        chk32("ov1_wa", bus.wa_o, 32'h0001_0000);
        chk32("ov1_wd", bus.wd_o, 32'h4433_2211);
        @(negedge clk);
        chk1 ("ov1_done",  done_o,       1'b1);
        chk32("ov1_words", 32'(words_o), 32'd1);
        chk32("ov1_wcnt",  32'(wr_cnt - base), 32'd1);

        // ---- 64-word load with random valid gaps ----
        pulse_start();
        base = wr_cnt;
        send_byte(8'h40, 1);
        send_byte(8'h00, 1);
        for (int i = 0; i < 64; i++) send_word(pat(i), 2);
        @(negedge clk);
        chk1 ("bp_done",  done_o,       1'b1);
        chk32("bp_words", 32'(words_o), 32'd64);
        chk32("bp_wcnt",  32'(wr_cnt - base), 32'd64);
        chk32("bp_last_wa", log_addr[8'(base + 63)], 32'h0001_00FC);
        for (int i = 0; i < 64; i++) begin
            chk32("bp_addr", log_addr[8'(base + i)], 32'h0001_0000 + 32'(i) * 4);
            chk32("bp_data", log_data[8'(base + i)], pat(i));
        end

        // ---- reset after the 2nd data byte of the third word ----
        pulse_start();
        base = wr_cnt;
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_word(32'h0BAD_F00D, 1);
        send_word(32'hC0FF_EE01, 1);
        send_byte(8'h77, 0);
        send_byte(8'h66, 0);
        reset = 1'b1;
        @(negedge clk);
        chk1 ("mr_busy",  busy_o,         1'b0);
        chk1 ("mr_cpu",   cpu_reset_o,    1'b0);
        chk1 ("mr_ready", bus.rx_ready_o, 1'b0);
        chk1 ("mr_we",    bus.we_o,       1'b0);
        chk1 ("mr_done",  done_o,         1'b0);
        chk1 ("mr_err",   err_o,          1'b0);
        chk32("mr_wa",    bus.wa_o,       32'h0);
        chk32("mr_wd",    bus.wd_o,       32'h0);
        chk32("mr_words", 32'(words_o),   32'h0);
        reset = 1'b0;
        bus.rx_data_i  = 8'h55;
        bus.rx_valid_i = 1'b1;
        repeat (4) @(negedge clk);
        bus.rx_valid_i = 1'b0;
        @(negedge clk);
        chk32("mr_wcnt", 32'(wr_cnt - base), 32'd2);
        chk32("mr_mem0", mem[0], 32'h0BAD_F00D);
        chk32("mr_mem1", mem[1], 32'hC0FF_EE01);
        chk32("mr_mem2", mem[2], pat(2));

        // ---- fresh load after the aborted one starts from lane 0 / word 0 ----
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h1357_9BDF, 0);
        chk32("post_wa", bus.wa_o, 32'h0001_0000);
        chk32("post_wd", bus.wd_o, 32'h1357_9BDF);
        @(negedge clk);
        chk1 ("post_done",  done_o,       1'b1);
        chk32("post_words", 32'(words_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
